// File: rtl/bomb_scheduler_if.sv
// Bundle between the bomberman/engine side (master) and the bomb scheduler (slave).
// Place request, chain-hit report, detonation valid/ready offer and per-slot status.
interface bomb_scheduler_if #(
    parameter int N_BOMBS = 4
);
    logic                   clear;
    logic                   place;
    logic [9:0]             b_x;
    logic [9:0]             b_y;
    logic                   chain_valid;
    logic [9:0]             chain_x;
    logic [9:0]             chain_y;
    logic                   expl_ready;
    logic                   expl_valid;
    logic [9:0]             expl_x;
    logic [9:0]             expl_y;
    logic                   place_ack;
    logic                   place_nack;
    logic [N_BOMBS-1:0]     slot_live;
    logic [20*N_BOMBS-1:0]  slot_xy;
    logic [3:0]             free_cnt;

    modport master (
        output clear, place, b_x, b_y, chain_valid, chain_x, chain_y, expl_ready,
        input  expl_valid, expl_x, expl_y, place_ack, place_nack, slot_live, slot_xy, free_cnt
    );

    modport slave (
        input  clear, place, b_x, b_y, chain_valid, chain_x, chain_y, expl_ready,
        output expl_valid, expl_x, expl_y, place_ack, place_nack, slot_live, slot_xy, free_cnt
    );
endinterface

// File: rtl/bomb_scheduler.sv
// Bomb slot allocator, per-slot fuse timers and round-robin share of the explosion engine.
// Latency: place->ack/nack 1 cycle, grant->offer 1 cycle; offer held stable until expl_ready.
module bomb_scheduler #(
    parameter int N_BOMBS     = 4,
    parameter int FUSE_CYCLES = 300000000,
    parameter int FUSE_W      = 29
) (
    input logic             clk,
    input logic             reset_n,
    bomb_scheduler_if.slave bus
);
    localparam int IDX_W = (N_BOMBS > 1) ? $clog2(N_BOMBS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PENDING} slot_state_t;

    slot_state_t            r_state [N_BOMBS];
    slot_state_t            w_state_nxt [N_BOMBS];
    logic [FUSE_W-1:0]      r_fuse [N_BOMBS];
    logic [FUSE_W-1:0]      w_fuse_nxt [N_BOMBS];
    logic [9:0]             r_x [N_BOMBS];
    logic [9:0]             r_y [N_BOMBS];
    logic [9:0]             w_x_nxt [N_BOMBS];
    logic [9:0]             w_y_nxt [N_BOMBS];

    logic                   r_expl_valid, w_expl_valid_nxt;
    logic [9:0]             r_expl_x, r_expl_y, w_expl_x_nxt, w_expl_y_nxt;
    logic [IDX_W-1:0]       r_grant, w_grant_nxt, r_rr, w_rr_nxt;
    logic                   r_place_ack, r_place_nack, w_ack_nxt, w_nack_nxt;
    logic [N_BOMBS-1:0]     r_slot_live, w_live_nxt;
    logic [20*N_BOMBS-1:0]  r_slot_xy, w_xy_nxt;
    logic [3:0]             r_free_cnt, w_free_nxt;

    logic                   w_idle_found, w_dup, w_pend_found;
    logic [IDX_W-1:0]       w_idle_idx, w_pend_idx;

    // Lowest free slot, duplicate-position guard and round-robin pick of pending slots.
    always_comb begin
        w_idle_found = 1'b0;
        w_idle_idx   = '0;
        w_dup        = 1'b0;
        w_pend_found = 1'b0;
        w_pend_idx   = '0;
        for (int i = N_BOMBS - 1; i >= 0; i--) begin
            if (r_state[i] == S_IDLE) begin
                w_idle_found = 1'b1;
                w_idle_idx   = IDX_W'(i);
            end
        end
        for (int i = 0; i < N_BOMBS; i++) begin
            if (r_state[i] != S_IDLE && r_x[i] == bus.b_x && r_y[i] == bus.b_y)
                w_dup = 1'b1;
        end
        for (int k = 0; k < N_BOMBS; k++) begin
            if (!w_pend_found &&
                r_state[IDX_W'((int'(r_rr) + k) % N_BOMBS)] == S_PENDING) begin
                w_pend_found = 1'b1;
                w_pend_idx   = IDX_W'((int'(r_rr) + k) % N_BOMBS);
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_fuse_nxt       = r_fuse;
        w_x_nxt          = r_x;
        w_y_nxt          = r_y;
        w_expl_valid_nxt = r_expl_valid;
        w_expl_x_nxt     = r_expl_x;
        w_expl_y_nxt     = r_expl_y;
        w_grant_nxt      = r_grant;
        w_rr_nxt         = r_rr;
        w_ack_nxt        = 1'b0;
        w_nack_nxt       = 1'b0;
        w_live_nxt       = '0;
        w_xy_nxt         = '0;
        w_free_nxt       = 4'd0;

        for (int i = 0; i < N_BOMBS; i++) begin
            case (r_state[i])
                S_ARMED: begin
                    if ((bus.chain_valid && bus.chain_x == r_x[i] && bus.chain_y == r_y[i]) ||
                        r_fuse[i] == '0)
                        w_state_nxt[i] = S_PENDING;
                    else
                        w_fuse_nxt[i] = r_fuse[i] - FUSE_W'(1);
                end
                S_PENDING: begin
                    if (r_expl_valid && bus.expl_ready && r_grant == IDX_W'(i))
                        w_state_nxt[i] = S_IDLE;
                end
                default: ;
            endcase
        end

        // Allocation looks only at current state, so a slot freed this cycle waits one cycle.
        if (bus.place) begin
            if (w_idle_found && !w_dup) begin
                w_state_nxt[w_idle_idx] = S_ARMED;
                w_fuse_nxt[w_idle_idx]  = FUSE_W'(FUSE_CYCLES - 1);
                w_x_nxt[w_idle_idx]     = bus.b_x;
                w_y_nxt[w_idle_idx]     = bus.b_y;
                w_ack_nxt               = 1'b1;
            end else begin
                w_nack_nxt = 1'b1;
            end
        end

        if (r_expl_valid) begin
            if (bus.expl_ready)
                w_expl_valid_nxt = 1'b0;
        end else if (w_pend_found) begin
            w_expl_valid_nxt = 1'b1;
            w_expl_x_nxt     = r_x[w_pend_idx];
            w_expl_y_nxt     = r_y[w_pend_idx];
            w_grant_nxt      = w_pend_idx;
            w_rr_nxt         = IDX_W'((int'(w_pend_idx) + 1) % N_BOMBS);
        end

        if (bus.clear) begin
            for (int i = 0; i < N_BOMBS; i++) begin
                w_state_nxt[i] = S_IDLE;
                w_fuse_nxt[i]  = '0;
                w_x_nxt[i]     = '0;
                w_y_nxt[i]     = '0;
            end
            w_expl_valid_nxt = 1'b0;
            w_expl_x_nxt     = '0;
            w_expl_y_nxt     = '0;
            w_grant_nxt      = '0;
            w_rr_nxt         = '0;
            w_ack_nxt        = 1'b0;
            w_nack_nxt       = 1'b0;
        end

        for (int i = 0; i < N_BOMBS; i++) begin
            w_live_nxt[i]        = (w_state_nxt[i] != S_IDLE);
            w_xy_nxt[20*i +: 20] = {w_y_nxt[i], w_x_nxt[i]};
            if (w_state_nxt[i] == S_IDLE)
                w_free_nxt = w_free_nxt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_BOMBS; i++) begin
                r_state[i] <= S_IDLE;
                r_fuse[i]  <= '0;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
            end
            r_expl_valid <= 1'b0;
            r_expl_x     <= '0;
            r_expl_y     <= '0;
            r_grant      <= '0;
            r_rr         <= '0;
            r_place_ack  <= 1'b0;
            r_place_nack <= 1'b0;
            r_slot_live  <= '0;
            r_slot_xy    <= '0;
            r_free_cnt   <= 4'(N_BOMBS);
        end else begin
            r_state      <= w_state_nxt;
            r_fuse       <= w_fuse_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_expl_valid <= w_expl_valid_nxt;
            r_expl_x     <= w_expl_x_nxt;
            r_expl_y     <= w_expl_y_nxt;
            r_grant      <= w_grant_nxt;
            r_rr         <= w_rr_nxt;
            r_place_ack  <= w_ack_nxt;
            r_place_nack <= w_nack_nxt;
            r_slot_live  <= w_live_nxt;
            r_slot_xy    <= w_xy_nxt;
            r_free_cnt   <= w_free_nxt;
        end
    end

    assign bus.expl_valid = r_expl_valid;
    assign bus.expl_x     = r_expl_x;
    assign bus.expl_y     = r_expl_y;
    assign bus.place_ack  = r_place_ack;
    assign bus.place_nack = r_place_nack;
    assign bus.slot_live  = r_slot_live;
    assign bus.slot_xy    = r_slot_xy;
    assign bus.free_cnt   = r_free_cnt;
endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler with FUSE_CYCLES=8, N_BOMBS=4; detonations are scoreboarded
// against a queue of expected {y,x} pushed when the bombs are placed.
module tb_bomb_scheduler;
    localparam int N = 4;
    localparam int F = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    bomb_scheduler_if #(.N_BOMBS(N)) bus ();

    bomb_scheduler #(.N_BOMBS(N), .FUSE_CYCLES(F), .FUSE_W(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [19:0] exp_q[$];
    int          det_cyc[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] xy(input int x, input int y);
        xy = {y[9:0], x[9:0]};
    endfunction

    // Every accepted detonation must be the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && !bus.clear && bus.expl_valid && bus.expl_ready) begin
            det_cyc.push_back(cyc);
            chk("det_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0)
                chk("det_xy", {bus.expl_y, bus.expl_x}, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_place(input int x, input int y, input logic exp_ack);
        bus.place = 1'b1;
        bus.b_x   = x[9:0];
        bus.b_y   = y[9:0];
        tick();
        bus.place = 1'b0;
        chk("place_ack", bus.place_ack, exp_ack);
        chk("place_nack", bus.place_nack, !exp_ack);
    endtask

    task automatic wait_valid(input int max);
        int n = 0;
        while (!bus.expl_valid && n < max) begin
            tick();
            n++;
        end
        chk("valid_timeout", bus.expl_valid, 1);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (!(bus.free_cnt == 4'(N) && !bus.expl_valid && exp_q.size() == 0) && n < max) begin
            tick();
            n++;
        end
        chk("drain_free", bus.free_cnt, N);
        chk("drain_queue", exp_q.size(), 0);
    endtask

    task automatic check_gaps();
        chk("det_count", det_cyc.size(), 4);
        for (int i = 1; i < det_cyc.size(); i++)
            chk("det_gap", det_cyc[i] - det_cyc[i-1], 2);
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    initial begin
        int t;
        int seen;
        bus.clear       = 1'b0;
        bus.place       = 1'b0;
        bus.b_x         = '0;
        bus.b_y         = '0;
        bus.chain_valid = 1'b0;
        bus.chain_x     = '0;
        bus.chain_y     = '0;
        bus.expl_ready  = 1'b1;

        repeat (2) tick();
        chk("rst_valid", bus.expl_valid, 0);
        chk("rst_live", bus.slot_live, 0);
        chk("rst_free", bus.free_cnt, N);
        chk("rst_ack", bus.place_ack, 0);
        chk("rst_xy", bus.slot_xy[31:0], 0);
        reset_n = 1'b1;
        tick();

        // Single bomb: fuse latency and handshake.
        t = cyc;
        exp_q.push_back(xy(32, 64));
        do_place(32, 64, 1'b1);
        chk("t1_live", bus.slot_live, 4'b0001);
        chk("t1_xy", bus.slot_xy[19:0], xy(32, 64));
        chk("t1_free", bus.free_cnt, 3);
        wait_valid(20);
        chk("t1_latency", cyc - t, 10);
        chk("t1_expl_xy", {bus.expl_y, bus.expl_x}, xy(32, 64));
        tick();
        chk("t1_drop", bus.expl_valid, 0);
        chk("t1_idle", bus.slot_live, 0);
        chk("t1_free_back", bus.free_cnt, N);

        // Five places two cycles apart: four acks then one nack.
        for (int i = 0; i < 5; i++) begin
            chk("t2_free_pre", bus.free_cnt, 4 - i);
            if (i < 4)
                exp_q.push_back(xy(100 + 16 * i, 200));
            do_place(100 + 16 * i, 200, i < 4);
            tick();
        end
        drain(100);

        // Same position while live is rejected.
        exp_q.push_back(xy(32, 64));
        do_place(32, 64, 1'b1);
        chk("t3_free_a", bus.free_cnt, 3);
        do_place(32, 64, 1'b0);
        chk("t3_free_b", bus.free_cnt, 3);
        drain(100);

        // All four pending, rr=0; first offer held for 20 cycles.
        pulse_clear();
        det_cyc.delete();
        bus.expl_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(xy(50 * i + 5, 300));
            do_place(50 * i + 5, 300, 1'b1);
        end
        wait_valid(20);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("hold_valid", bus.expl_valid, 1);
            chk("hold_xy", {bus.expl_y, bus.expl_x}, xy(5, 300));
        end
        chk("hold_live", bus.slot_live, 4'hF);
        bus.expl_ready = 1'b1;
        drain(100);
        check_gaps();

        // Advance rr to 2, then slot2 chain-hit first: order 2,3,0,1.
        exp_q.push_back(xy(600, 10));
        exp_q.push_back(xy(610, 10));
        do_place(600, 10, 1'b1);
        do_place(610, 10, 1'b1);
        drain(100);
        det_cyc.delete();
        bus.expl_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            do_place(40 * i + 3, 400, 1'b1);
        bus.chain_valid = 1'b1;
        bus.chain_x     = 10'd83;
        bus.chain_y     = 10'd400;
        tick();
        bus.chain_valid = 1'b0;
        exp_q.push_back(xy(83, 400));
        exp_q.push_back(xy(123, 400));
        exp_q.push_back(xy(3, 400));
        exp_q.push_back(xy(43, 400));
        wait_valid(20);
        chk("rr2_first", {bus.expl_y, bus.expl_x}, xy(83, 400));
        repeat (12) tick();
        bus.expl_ready = 1'b1;
        drain(100);
        check_gaps();

        // Chain hit on fuse cycle 2 of slot1, then clear during the offer.
        pulse_clear();
        bus.expl_ready = 1'b0;
        do_place(32, 64, 1'b1);
        do_place(96, 64, 1'b1);
        tick();
        bus.chain_valid = 1'b1;
        bus.chain_x     = 10'd96;
        bus.chain_y     = 10'd64;
        tick();
        bus.chain_valid = 1'b0;
        tick();
        chk("chain_valid", bus.expl_valid, 1);
        chk("chain_xy", {bus.expl_y, bus.expl_x}, xy(96, 64));
        chk("chain_live", bus.slot_live, 4'b0011);
        bus.clear      = 1'b1;
        bus.expl_ready = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_valid", bus.expl_valid, 0);
        chk("clr_live", bus.slot_live, 0);
        chk("clr_free", bus.free_cnt, N);
        chk("clr_xy", bus.slot_xy[31:0], 0);

        // Asynchronous reset mid-fuse.
        do_place(500, 500, 1'b1);
        repeat (3) tick();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_live", bus.slot_live, 0);
        chk("arst_free", bus.free_cnt, N);
        chk("arst_valid", bus.expl_valid, 0);
        chk("arst_xy", bus.slot_xy[31:0], 0);
        reset_n = 1'b1;
        seen = 0;
        repeat (20) begin
            tick();
            if (bus.expl_valid)
                seen++;
        end
        chk("arst_quiet", seen, 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
